pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter PIXEL_DIV, default 10: clk cycles per pixel strobe; legal range 2..255.
REQ-002 Parameter H_START, default 120: clk cycles from newline to first active cycle; legal range 1..4095.
REQ-003 Parameter FRAMES_PER_PATTERN, default 150: frames each pattern is shown in auto mode; legal range 1..1023.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port newline, input, 1: one-cycle strobe at start of each scanline.
REQ-007 Port newframe, input, 1: one-cycle strobe at start of each frame.
REQ-008 Port line_active, input, 1: current line is in the vertical visible region; sampled on newline.
REQ-009 Port auto_en, input, 1: level; enables timed pattern advance.
REQ-010 Port step, input, 1: one-cycle request to advance pattern at next frame boundary.
REQ-011 Port newpixel, output, 1: one-cycle pixel strobe to the color bar generator.
REQ-012 Port visible_window, output, 1: high while the 256-pixel active span runs.
REQ-013 Port video_y, output, 8: pattern control byte for the color bar generator.
REQ-014 Port pattern_idx, output, 2: currently displayed pattern number.

Function
REQ-015 Line FSM states: WAIT, ACTIVE, DONE; every newline forces WAIT with delay counter 0 and pixel counter 0, from any state, including aborting ACTIVE.
REQ-016 WAIT: delay counter increments each cycle; on reaching H_START-1, next state is ACTIVE.
REQ-017 ACTIVE: divider counts 0..PIXEL_DIV-1 and wraps; newpixel = 1 in the cycle the divider equals PIXEL_DIV-1, else 0.
REQ-018 ACTIVE: 9-bit pixel counter increments on each newpixel; the 256th strobe moves state to DONE the following cycle.
REQ-019 visible_window = 1 only in ACTIVE and only if line_active was 1 at the latest newline; newpixel is gated by the same condition.
REQ-020 DONE: newpixel = 0 and visible_window = 0 until next newline.
REQ-021 newpixel and visible_window are registered; exactly 256 newpixel strobes per active line, spaced PIXEL_DIV cycles apart.
REQ-022 Pattern map: idx 0 = 75% normal, 1 = 100% normal, 2 = 75% reversed, 3 = 100% reversed; video_y = {idx[1], idx[0], 6'b0}.
REQ-023 step sets a pending flag; a step coinciding with newframe counts for that same frame boundary.
REQ-024 10-bit frame counter increments on each newframe while auto_en = 1; it is held while auto_en = 0.
REQ-025 At newframe, advance when pending = 1 or (auto_en = 1 and frame counter = FRAMES_PER_PATTERN-1).
REQ-026 On advance: idx increments modulo 4 (3 wraps to 0); pending clears; frame counter clears.
REQ-027 If both advance conditions are true at the same newframe, the pattern advances once only.
REQ-028 video_y and pattern_idx change only in the cycle after newframe, never mid-frame.
REQ-029 newline and newframe in the same cycle are both honoured independently.

Reset
REQ-030 While rst = 1, state is WAIT and all counters, idx and pending are 0.
REQ-031 While rst = 1, newpixel = 0, visible_window = 0, video_y = 8'h00, pattern_idx = 0.
REQ-032 Reset asserted mid-line aborts the line immediately; after release, no newpixel occurs until a newline has been seen.

Verification
REQ-033 Defaults, line_active = 1, newline at t0 -> first newpixel at t0+120+9 (±1 for register stage); 256 strobes, 10 cycles apart; visible_window falls after the 256th strobe.
REQ-034 line_active = 0 at newline -> zero newpixel strobes; visible_window stays 0 for the whole line.
REQ-035 Second newline 1000 cycles into ACTIVE -> pixel count restarts; a fresh 256-strobe sequence follows H_START later.
REQ-036 auto_en = 1, FRAMES_PER_PATTERN = 3 -> video_y steps 00, 40, 80, C0, 00 every 3 frames; updates only after newframe.
REQ-037 auto_en = 0, step mid-frame -> video_y 00 -> 40 one cycle after next newframe; step plus expiry on same newframe -> single advance.
REQ-038 rst pulse during ACTIVE at pattern 2 -> outputs 0 immediately; video_y = 00; no strobes until next newline.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Scanline pixel-strobe generator plus frame-timed test-pattern selector for a colour bar generator.
// newpixel/visible_window are registered (one cycle after the divider hits); no backpressure, strobe-driven.
module pattern_sequencer #(
  parameter int PIXEL_DIV          = 10,
  parameter int H_START            = 120,
  parameter int FRAMES_PER_PATTERN = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newline,
  input  logic       newframe,
  input  logic       line_active,
  input  logic       auto_en,
  input  logic       step,
  output logic       newpixel,
  output logic       visible_window,
  output logic [7:0] video_y,
  output logic [1:0] pattern_idx
);

  localparam logic [7:0]  DIV_LAST = 8'(PIXEL_DIV - 1);
  localparam logic [11:0] H_LAST   = 12'(H_START - 1);
  localparam logic [9:0]  F_LAST   = 10'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] dly_cnt, dly_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [8:0]  pix_cnt, pix_nxt;
  logic        pix_tick;
  logic        vis_en;
  logic [9:0]  frame_cnt;
  logic [1:0]  idx;
  logic        pending;
  logic        advance;

  // Line FSM: newline restarts the line from any state, aborting a running span.
  always_comb begin
    state_nxt = state;
    dly_nxt   = dly_cnt;
    div_nxt   = div_cnt;
    pix_nxt   = pix_cnt;
    pix_tick  = 1'b0;
    if (newline) begin
      state_nxt = S_WAIT;
      dly_nxt   = '0;
      div_nxt   = '0;
      pix_nxt   = '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (dly_cnt == H_LAST) begin
            state_nxt = S_ACTIVE;
            div_nxt   = '0;
          end else begin
            dly_nxt = dly_cnt + 12'd1;
          end
        end
        S_ACTIVE: begin
          if (div_cnt == DIV_LAST) begin
            div_nxt  = '0;
            pix_tick = 1'b1;
            pix_nxt  = pix_cnt + 9'd1;
            if (pix_cnt == 9'd255) state_nxt = S_DONE;
          end else begin
            div_nxt = div_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // vis_en resets low so a released reset produces no strobes until a newline re-arms it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_WAIT;
      dly_cnt        <= '0;
      div_cnt        <= '0;
      pix_cnt        <= '0;
      vis_en         <= 1'b0;
      newpixel       <= 1'b0;
      visible_window <= 1'b0;
    end else begin
      state          <= state_nxt;
      dly_cnt        <= dly_nxt;
      div_cnt        <= div_nxt;
      pix_cnt        <= pix_nxt;
      if (newline) vis_en <= line_active;
      newpixel       <= pix_tick & vis_en;
      visible_window <= (state == S_ACTIVE) & vis_en & ~newline;
    end
  end

  // A step arriving with newframe is folded into that same boundary.
  assign advance = newframe & (pending | step | (auto_en & (frame_cnt == F_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else if (advance) begin
      idx       <= idx + 2'd1;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (step) pending <= 1'b1;
      if (newframe && auto_en) frame_cnt <= frame_cnt + 10'd1;
    end
  end

  assign pattern_idx = idx;
  assign video_y     = {idx[1], idx[0], 6'b0};

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: line strobe timing sequences plus a vector table for pattern advance.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst, newline, newframe, line_active, auto_en, step;
  logic       newpixel, visible_window;
  logic [7:0] video_y;
  logic [1:0] pattern_idx;

  int total = 0;
  int bad   = 0;
  int m_first, m_count, m_last, m_vw_first, m_vw_last, m_gap_err;

  typedef struct {
    logic       nf;
    logic       ae;
    logic       st;
    logic [1:0] idx;
  } vec_t;
  vec_t vecs[24];

  always #5 clk = ~clk;

  pattern_sequencer #(
    .PIXEL_DIV(10),
    .H_START(120),
    .FRAMES_PER_PATTERN(3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .newline(newline),
    .newframe(newframe),
    .line_active(line_active),
    .auto_en(auto_en),
    .step(step),
    .newpixel(newpixel),
    .visible_window(visible_window),
    .video_y(video_y),
    .pattern_idx(pattern_idx)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic la);
    newline     = 1'b1;
    line_active = la;
    tick();
    newline = 1'b0;
  endtask

  // Cycle c is sampled just after the c-th clock edge following the newline edge.
  task automatic measure(input int n);
    int prev;
    prev = -1;
    m_first = -1; m_count = 0; m_last = -1;
    m_vw_first = -1; m_vw_last = -1; m_gap_err = 0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (newpixel) begin
        if (m_first < 0) m_first = c;
        if (prev >= 0 && (c - prev) != 10) m_gap_err++;
        prev = c;
        m_last = c;
        m_count++;
      end
      if (visible_window) begin
        if (m_vw_first < 0) m_vw_first = c;
        m_vw_last = c;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd2};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd3};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd3};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 2'd3};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 2'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 2'd0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 2'd1};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 2'd2};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 2'd2};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 2'd2};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 2'd2};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 2'd2};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 2'd3};

    rst = 1'b1; newline = 1'b0; newframe = 1'b0; line_active = 1'b0;
    auto_en = 1'b0; step = 1'b0;
    repeat (3) tick();
    check("rst_newpixel", int'(newpixel), 0);
    check("rst_visible", int'(visible_window), 0);
    check("rst_video_y", int'(video_y), 0);
    check("rst_idx", int'(pattern_idx), 0);
    rst = 1'b0;
    tick();

    // Full visible line with default timing.
    start_line(1'b1);
    measure(2800);
    check("line_first_strobe", m_first, 130);
    check("line_strobe_count", m_count, 256);
    check("line_last_strobe", m_last, 2680);
    check("line_spacing_errs", m_gap_err, 0);
    check("line_vw_rise", m_vw_first, 121);
    check("line_vw_fall", m_vw_last, 2680);

    // Line outside the vertical visible region.
    start_line(1'b0);
    measure(2800);
    check("blank_strobe_count", m_count, 0);
    check("blank_vw_seen", m_vw_first, -1);

    // Second newline lands 1000 cycles into the first line.
    start_line(1'b1);
    measure(999);
    check("abort_pre_count", m_count, 87);
    start_line(1'b1);
    measure(2800);
    check("abort_first_strobe", m_first, 130);
    check("abort_strobe_count", m_count, 256);
    check("abort_spacing_errs", m_gap_err, 0);

    // Pattern advance table.
    for (int i = 0; i < 24; i++) begin
      newframe = vecs[i].nf;
      auto_en  = vecs[i].ae;
      step     = vecs[i].st;
      tick();
      newframe = 1'b0;
      step     = 1'b0;
      check($sformatf("vec%0d_idx", i), int'(pattern_idx), int'(vecs[i].idx));
      check($sformatf("vec%0d_video_y", i), int'(video_y), int'(vecs[i].idx) * 64);
    end

    // Walk 3 -> 0 -> 1 -> 2 with manual steps.
    auto_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0; tick();
      newframe = 1'b1; tick(); newframe = 1'b0;
    end
    check("walk_idx", int'(pattern_idx), 2);
    check("walk_video_y", int'(video_y), 8'h80);

    // Asynchronous reset in the middle of an active span.
    start_line(1'b1);
    measure(300);
    check("pre_rst_visible", int'(visible_window), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_visible", int'(visible_window), 0);
    check("midrst_newpixel", int'(newpixel), 0);
    check("midrst_video_y", int'(video_y), 0);
    check("midrst_idx", int'(pattern_idx), 0);
    tick();
    rst = 1'b0;
    measure(3000);
    check("postrst_strobe_count", m_count, 0);
    check("postrst_vw_seen", m_vw_first, -1);
    newframe = 1'b1; tick(); newframe = 1'b0;
    check("postrst_no_pending", int'(pattern_idx), 0);
    start_line(1'b1);
    measure(200);
    check("postrst_first_strobe", m_first, 130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
